pulse_freq_meter: RTL and testbench



---
 rtl/pulse_meter_pkg.sv | 13 +
 rtl/pulse_freq_meter_gate_timer.sv | 38 +++
 rtl/pulse_freq_meter.sv | 116 +++++++++++
 tb/tb_pulse_freq_meter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the gated pulse frequency meter.
// Imported by the timer and the top level.
package pulse_meter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } meter_state_t;

    localparam int unsigned DEF_GATE_CYCLES = 27_000_000;
    localparam int unsigned DEF_CNT_W       = 24;

endpackage

// File: rtl/pulse_freq_meter_gate_timer.sv
// Terminal counter for fixed-length measurement windows.
// Runs 0..N-1 while en is high; last strobes on N-1 and wraps.
module gate_timer
    import pulse_meter_pkg::*;
#(
    parameter int unsigned N = DEF_GATE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned TW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] LAST_T = TW'(N - 1);

    logic [TW-1:0] timer_q;
    logic          at_last;

    assign at_last = (timer_q == LAST_T);
    assign last    = en && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (clr) begin
            timer_q <= '0;
        end else if (en) begin
            if (at_last) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_freq_meter.sv
// Gated edge counter: counts edge_in pulses over GATE_CYCLES clocks and
// publishes each window's result on a valid/ready output register.
module pulse_freq_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             edge_in,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic [CNT_W-1:0] freq_count,
    output logic             overflow,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t state_q;
    meter_state_t state_d;
    logic         run;
    logic         win_end;

    logic [CNT_W-1:0] count_q;
    logic             sat_q;
    logic [CNT_W-1:0] count_next;
    logic             sat_next;
    logic             at_max;

    logic [CNT_W-1:0] res_count_q;
    logic             res_ovf_q;
    logic             res_ovr_q;
    logic             res_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping enable in COUNT aborts, including on the window-end cycle.
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (enable) begin
                    run = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    gate_timer #(
        .N (GATE_CYCLES)
    ) u_gate_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!run),
        .en    (run),
        .last  (win_end)
    );

    assign at_max     = (count_q == CNT_MAX);
    assign count_next = at_max ? CNT_MAX : count_q + CNT_W'(edge_in);
    assign sat_next   = sat_q || (edge_in && at_max);

    // Window end restarts at zero so the next cycle opens a new window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (!run || win_end) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            sat_q   <= sat_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
            res_ovr_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (win_end) begin
            res_count_q <= count_next;
            res_ovf_q   <= sat_next;
            res_ovr_q   <= res_valid_q && !freq_ready;
            res_valid_q <= 1'b1;
        end else if (res_valid_q && freq_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign freq_valid = res_valid_q;
    assign freq_count = res_count_q;
    assign overflow   = res_ovf_q;
    assign overrun    = res_ovr_q;

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Directed bench for pulse_freq_meter at GATE_CYCLES=10, CNT_W=4 and 3.
module tb_pulse_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       edge_in;
    logic       freq_ready;

    logic       valid4;
    logic [3:0] count4;
    logic       ovf4;
    logic       ovr4;

    logic       valid3;
    logic [2:0] count3;
    logic       ovf3;
    logic       ovr3;

    int checks   = 0;
    int failures = 0;

    pulse_freq_meter #(.GATE_CYCLES(10), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .edge_in    (edge_in),
        .freq_valid (valid4),
        .freq_ready (freq_ready),
        .freq_count (count4),
        .overflow   (ovf4),
        .overrun    (ovr4)
    );

    pulse_freq_meter #(.GATE_CYCLES(10), .CNT_W(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .edge_in    (edge_in),
        .freq_valid (valid3),
        .freq_ready (freq_ready),
        .freq_count (count3),
        .overflow   (ovf3),
        .overrun    (ovr3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] mask;
        int         c4;
        int         c3;
        logic       o3;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string name);
        chk({name, "_valid4"}, valid4, 0);
        chk({name, "_count4"}, count4, 0);
        chk({name, "_ovf4"}, ovf4, 0);
        chk({name, "_ovr4"}, ovr4, 0);
        chk({name, "_valid3"}, valid3, 0);
        chk({name, "_count3"}, count3, 0);
        chk({name, "_ovf3"}, ovf3, 0);
        chk({name, "_ovr3"}, ovr3, 0);
    endtask

    task automatic go_idle();
        enable     = 1'b0;
        edge_in    = 1'b0;
        freq_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        // mask bit i = edge in the cycle with timer = i
        vecs[0] = '{10'b1010101010, 5, 5, 1'b0};
        vecs[1] = '{10'b1111111111, 10, 7, 1'b1};
        vecs[2] = '{10'b0000000000, 0, 0, 1'b0};
        vecs[3] = '{10'b1000000000, 1, 1, 1'b0};
        vecs[4] = '{10'b0000000001, 1, 1, 1'b0};
        vecs[5] = '{10'b0001111111, 7, 7, 1'b0};
        vecs[6] = '{10'b0011111111, 8, 7, 1'b1};

        rst_n      = 1'b0;
        enable     = 1'b0;
        edge_in    = 1'b0;
        freq_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_valid", valid4, 0);

        for (int v = 0; v < 7; v++) begin
            enable = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                tick();
                edge_in = vecs[v].mask[c-1];
                if (c == 10) chk("vec_early_valid", valid4, 0);
            end
            tick();
            edge_in = 1'b0;
            chk($sformatf("vec%0d_valid4", v), valid4, 1);
            chk($sformatf("vec%0d_count4", v), count4, vecs[v].c4);
            chk($sformatf("vec%0d_ovf4", v), ovf4, 0);
            chk($sformatf("vec%0d_ovr4", v), ovr4, 0);
            chk($sformatf("vec%0d_valid3", v), valid3, 1);
            chk($sformatf("vec%0d_count3", v), count3, vecs[v].c3);
            chk($sformatf("vec%0d_ovf3", v), ovf3, vecs[v].o3);
            enable = 1'b0;
            tick();
            chk($sformatf("vec%0d_pulse", v), valid4, 0);
            tick();
            tick();
        end

        // back-to-back windows, edges straddling the boundary
        enable = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 11) begin
                chk("bnd_w1_valid", valid4, 1);
                chk("bnd_w1_count", count4, 1);
            end
            if (c == 12) chk("bnd_w1_pulse", valid4, 0);
            if (c == 21) begin
                chk("bnd_w2_valid", valid4, 1);
                chk("bnd_w2_count", count4, 1);
            end
            edge_in = (c == 10) || (c == 11);
        end
        go_idle();

        // backpressure across two windows
        freq_ready = 1'b0;
        enable     = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 11) begin
                chk("bp_w1_valid", valid4, 1);
                chk("bp_w1_count", count4, 3);
                chk("bp_w1_ovr", ovr4, 0);
            end
            if (c == 15) begin
                chk("bp_hold_valid", valid4, 1);
                chk("bp_hold_count", count4, 3);
            end
            if (c == 21) begin
                chk("bp_w2_valid", valid4, 1);
                chk("bp_w2_count", count4, 4);
                chk("bp_w2_ovr", ovr4, 1);
                freq_ready = 1'b1;
            end
            if (c == 22) begin
                chk("bp_drain_valid", valid4, 0);
                chk("bp_drain_count", count4, 4);
                chk("bp_drain_ovr", ovr4, 1);
            end
            edge_in = (c <= 3) || (c >= 11 && c <= 14);
        end
        go_idle();

        // abort at timer=5, then a full window after re-enable
        enable = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            if (c >= 7 && c <= 22) chk("abort_no_result", valid4, 0);
            if (c == 23) begin
                chk("abort_re_valid", valid4, 1);
                chk("abort_re_count", count4, 10);
            end
            edge_in = 1'b1;
            if (c == 6) enable = 1'b0;
            if (c == 12) enable = 1'b1;
        end
        go_idle();

        // asynchronous reset with a pending result
        freq_ready = 1'b0;
        enable     = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 11) begin
                chk("rst_pre_valid", valid4, 1);
                chk("rst_pre_count", count4, 2);
            end
            edge_in = (c <= 2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        enable     = 1'b0;
        edge_in    = 1'b0;
        freq_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("rst_idle_valid", valid4, 0);
            edge_in = c[0];
        end
        edge_in = 1'b0;
        enable  = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 10) chk("rst_re_early", valid4, 0);
            if (c == 11) begin
                chk("rst_re_valid", valid4, 1);
                chk("rst_re_count", count4, 3);
            end
            edge_in = (c == 2) || (c == 5) || (c == 9);
        end
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
